// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch unit and its instruction ROM.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned INST_W = 9;
    localparam int unsigned CNT_W  = 16;

    localparam logic [INST_W-1:0] HALT_INST = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit control and ROM bus; master is the fetch unit, slave is the harness/ROM side.
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int unsigned A  = ADDR_W,
    parameter int unsigned W  = INST_W,
    parameter int unsigned CW = CNT_W
);
    logic          Start;
    logic [A-1:0]  StartAddr;
    logic          Stall;
    logic          BranchAbs;
    logic [A-1:0]  Target;
    logic          BranchRel;
    logic [A-1:0]  Offset;
    logic [W-1:0]  InstIn;
    logic [A-1:0]  InstAddress;
    logic          InstValid;
    logic          Done;
    logic [CW-1:0] CycleCount;

    modport master (
        input  Start, StartAddr, Stall, BranchAbs, Target, BranchRel, Offset, InstIn,
        output InstAddress, InstValid, Done, CycleCount
    );

    modport slave (
        output Start, StartAddr, Stall, BranchAbs, Target, BranchRel, Offset, InstIn,
        input  InstAddress, InstValid, Done, CycleCount
    );
endinterface

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC selection: stall/halt hold, then absolute, relative, increment.
module pc_next
    import inst_fetch_pkg::*;
#(
    parameter int unsigned A = ADDR_W
) (
    input  logic [A-1:0] pc,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_abs,
    input  logic [A-1:0] target,
    input  logic         branch_rel,
    input  logic [A-1:0] offset,
    output logic [A-1:0] next_pc
);

    // Additions are A bits wide, so both wrap directions fall out of truncation.
    always_comb begin
        next_pc = pc + 1'b1;
        if (stall || halt) begin
            next_pc = pc;
        end else if (branch_abs) begin
            next_pc = target;
        end else if (branch_rel) begin
            next_pc = pc + offset;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Program counter, IDLE/RUN/HALTED sequencer and saturating RUN-cycle counter.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned A  = ADDR_W,
    parameter int unsigned W  = INST_W,
    parameter int unsigned CW = CNT_W
) (
    input  logic         Clk,
    input  logic         Reset,
    inst_fetch_if.master bus
);

    state_e        state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [A-1:0]  pc_run;
    logic          halt;

    assign halt = &bus.InstIn;

    pc_next #(.A(A)) u_pc_next (
        .pc         (pc_q),
        .stall      (bus.Stall),
        .halt       (halt),
        .branch_abs (bus.BranchAbs),
        .target     (bus.Target),
        .branch_rel (bus.BranchRel),
        .offset     (bus.Offset),
        .next_pc    (pc_run)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                pc_d = pc_run;
                // A stalled cycle masks the HALT word just like it masks branches.
                if (!bus.Stall && halt) begin
                    done_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstValid   = (state_q == RUN) && !bus.Stall;
    assign bus.Done        = done_q;
    assign bus.CycleCount  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plan scenarios plus random stimulus against a behavioural fetch model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int unsigned A  = 12;
    localparam int unsigned W  = 9;
    localparam int unsigned CW = 16;

    logic Clk = 1'b0;
    logic Reset;

    inst_fetch_if #(.A(A), .W(W), .CW(CW)) bus ();
    inst_fetch_if #(.A(A), .W(W), .CW(4))  bus_s ();

    inst_fetch #(.A(A), .W(W), .CW(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Narrow-counter copy sharing the same stimulus, to reach counter saturation quickly.
    inst_fetch #(.A(A), .W(W), .CW(4)) dut_sat (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_s)
    );

    always #5 Clk = ~Clk;

    logic [W-1:0] rom [0:4095];

    assign bus.InstIn      = rom[bus.InstAddress];
    assign bus_s.InstIn    = rom[bus_s.InstAddress];
    assign bus_s.Start     = bus.Start;
    assign bus_s.StartAddr = bus.StartAddr;
    assign bus_s.Stall     = bus.Stall;
    assign bus_s.BranchAbs = bus.BranchAbs;
    assign bus_s.Target    = bus.Target;
    assign bus_s.BranchRel = bus.BranchRel;
    assign bus_s.Offset    = bus.Offset;

    int n_total = 0;
    int n_bad   = 0;

    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;
    int m_cnt_s;
    int c0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit st, input int sa, input bit stl,
                         input bit ba, input int tg, input bit br, input int off);
        Reset         = rst;
        bus.Start     = st;
        bus.StartAddr = A'(sa);
        bus.Stall     = stl;
        bus.BranchAbs = ba;
        bus.Target    = A'(tg);
        bus.BranchRel = br;
        bus.Offset    = A'(off);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check the combinational valid, advance the model, check registered outputs.
    task automatic tick();
        #2;
        check_val("inst_valid", 32'(bus.InstValid), 32'(m_run && !bus.Stall));
        if (Reset) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
        end else if (!m_run) begin
            if (bus.Start) begin
                m_pc = int'(bus.StartAddr); m_cnt = 0; m_cnt_s = 0; m_run = 1; m_done = 0;
            end
        end else begin
            m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : m_cnt;
            m_cnt_s = (m_cnt_s < 15)    ? m_cnt_s + 1 : m_cnt_s;
            if (bus.Stall) begin
                m_pc = m_pc;
            end else if (rom[m_pc] == HALT_INST) begin
                m_run = 0; m_done = 1;
            end else if (bus.BranchAbs) begin
                m_pc = int'(bus.Target);
            end else if (bus.BranchRel) begin
                m_pc = (m_pc + int'(bus.Offset)) % 4096;
            end else begin
                m_pc = (m_pc + 1) % 4096;
            end
        end
        @(posedge Clk);
        #1;
        check_val("pc",         32'(bus.InstAddress),  32'(m_pc));
        check_val("done",       32'(bus.Done),         32'(m_done));
        check_val("cycles",     32'(bus.CycleCount),   32'(m_cnt));
        check_val("cycles_sat", 32'(bus_s.CycleCount), 32'(m_cnt_s));
        check_val("pc_sat",     32'(bus_s.InstAddress), 32'(m_pc));
    endtask

    initial begin
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
        for (int i = 0; i < 4096; i++) rom[i] = '0;
        rom[4] = HALT_INST;
        rom[7] = HALT_INST;

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_val("rst_pc",    32'(bus.InstAddress), 32'h0);
        check_val("rst_valid", 32'(bus.InstValid),   32'h0);
        check_val("rst_done",  32'(bus.Done),        32'h0);
        check_val("rst_cnt",   32'(bus.CycleCount),  32'h0);

        // 1: straight-line run into HALT at address 4
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        repeat (5) begin idle(); tick(); end
        check_val("t1_done", 32'(bus.Done),        32'h1);
        check_val("t1_cnt",  32'(bus.CycleCount),  32'd5);
        check_val("t1_pc",   32'(bus.InstAddress), 32'h4);
        repeat (2) begin idle(); tick(); end
        check_val("t1_frozen_pc",  32'(bus.InstAddress), 32'h4);
        check_val("t1_frozen_cnt", 32'(bus.CycleCount),  32'd5);

        // 2: absolute wins over relative, then negative relative
        drive(0, 1, 10, 0, 0, 0, 0, 0);
        tick();
        check_val("t2_start", 32'(bus.InstAddress), 32'd10);
        drive(0, 0, 0, 0, 1, 'h100, 1, 3);
        tick();
        check_val("t2_abs", 32'(bus.InstAddress), 32'h100);
        drive(0, 0, 0, 0, 0, 0, 1, 'hFFE);
        tick();
        check_val("t2_rel", 32'(bus.InstAddress), 32'h0FE);

        // 3: wrap on increment and on negative relative
        drive(0, 0, 0, 0, 1, 'hFFF, 0, 0);
        tick();
        idle();
        tick();
        check_val("t3_inc_wrap", 32'(bus.InstAddress), 32'h000);
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 'hFFC);
        tick();
        check_val("t3_rel_wrap", 32'(bus.InstAddress), 32'hFFE);

        // 4: stall masks the HALT word at PC=7
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        c0 = int'(bus.CycleCount);
        repeat (3) begin
            drive(0, 0, 0, 1, 1, 'h123, 1, 5);
            tick();
            check_val("t4_pc",   32'(bus.InstAddress), 32'd7);
            check_val("t4_done", 32'(bus.Done),        32'h0);
        end
        check_val("t4_cnt", 32'(bus.CycleCount), 32'(c0 + 3));
        idle();
        tick();
        check_val("t4_halt", 32'(bus.Done), 32'h1);

        // 5: Start ignored in RUN, then reset mid-run at 0x055
        drive(0, 1, 'h50, 0, 0, 0, 0, 0);
        tick();
        repeat (3) begin idle(); tick(); end
        drive(0, 1, 'h300, 0, 0, 0, 0, 0);
        tick();
        check_val("t5_start_ignored", 32'(bus.InstAddress), 32'h54);
        idle();
        tick();
        check_val("t5_pc", 32'(bus.InstAddress), 32'h55);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_val("t5_rst_pc",   32'(bus.InstAddress), 32'h0);
        check_val("t5_rst_done", 32'(bus.Done),        32'h0);
        check_val("t5_rst_cnt",  32'(bus.CycleCount),  32'h0);
        idle();
        tick();
        check_val("t5_idle_pc", 32'(bus.InstAddress), 32'h0);

        // 6: restart from HALTED
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        repeat (5) begin idle(); tick(); end
        check_val("t6_halted", 32'(bus.Done), 32'h1);
        drive(0, 1, 'h20, 0, 0, 0, 0, 0);
        tick();
        check_val("t6_done", 32'(bus.Done),        32'h0);
        check_val("t6_pc",   32'(bus.InstAddress), 32'h20);
        check_val("t6_cnt0", 32'(bus.CycleCount),  32'h0);
        idle();
        tick();
        check_val("t6_cnt1", 32'(bus.CycleCount), 32'h1);

        // Counter saturation on the narrow instance
        repeat (20) begin idle(); tick(); end
        check_val("sat_cnt", 32'(bus_s.CycleCount), 32'd15);
        check_val("wide_cnt", 32'(bus.CycleCount),  32'd21);

        // Random phase
        for (int i = 0; i < 4096; i++)
            rom[i] = ($urandom_range(0, 31) == 0) ? HALT_INST : W'($urandom_range(0, 510));
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                  int'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 4095)),
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 4095)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
